// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - register file with two bypassed read ports and a busy scoreboard
module reg_file_bypass #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_hazard,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_hazard,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  output logic [DEPTH-1:0] busy
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic             w_ok;
  logic             i_ok;
  logic             wr_hit;

  // An address is usable when it names a real register that is not the hard-wired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'({1'b0, a}) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_ok   = addr_ok(waddr);
  assign i_ok   = addr_ok(iss_addr);
  // A writeback only counts outside reset; reset suppresses bypass and hazard resolution.
  assign wr_hit = !rst && we && w_ok;

  // Port A: forward this cycle's writeback, else the stored value; unusable addresses read 0.
  always_comb begin
    ra_data   = '0;
    ra_hazard = 1'b0;
    if (wr_hit && (waddr == ra_addr)) begin
      ra_data = wdata;
    end else if (addr_ok(ra_addr)) begin
      ra_data   = regs[ra_addr];
      ra_hazard = !rst && busy_q[ra_addr];
    end
  end

  // Port B: same forwarding and hazard rules as port A.
  always_comb begin
    rb_data   = '0;
    rb_hazard = 1'b0;
    if (wr_hit && (waddr == rb_addr)) begin
      rb_data = wdata;
    end else if (addr_ok(rb_addr)) begin
      rb_data   = regs[rb_addr];
      rb_hazard = !rst && busy_q[rb_addr];
    end
  end

  // Storage: reset clears every register; a valid writeback updates one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && w_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Scoreboard: writeback clears first, then issue sets, so a same-address issue wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (we && w_ok) begin
        busy_q[waddr] <= 1'b0;
      end
      if (iss_valid && i_ok) begin
        busy_q[iss_addr] <= 1'b1;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_reg_file_bypass.sv
// tb/tb_reg_file_bypass.sv - vector-table bench for reg_file_bypass (default, zero-reg and depth-6 builds)
module tb_reg_file_bypass;

  typedef struct {
    int          id;
    int          sel;      // 0 default build, 1 ZERO_REG build, 2 DEPTH=6 build
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        iss;
    logic [2:0]  iaddr;
    logic [15:0] exp_ra;
    logic [15:0] exp_rb;
    logic        exp_ha;
    logic        exp_hb;
    logic [7:0]  exp_busy;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic        iss_valid;
  logic [2:0]  iss_addr;

  logic [15:0] ra_data, rb_data, ra_data_z, rb_data_z, ra_data_d, rb_data_d;
  logic        ra_hazard, rb_hazard, ra_hazard_z, rb_hazard_z, ra_hazard_d, rb_hazard_d;
  logic [7:0]  busy, busy_z;
  logic [5:0]  busy_d;

  int total = 0;
  int bad   = 0;
  vec_t exp_q[$];
  vec_t tbl[19];

  reg_file_bypass #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .ra_data(ra_data), .ra_hazard(ra_hazard),
    .rb_addr(rb_addr), .rb_data(rb_data), .rb_hazard(rb_hazard),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy(busy)
  );

  reg_file_bypass #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .ra_data(ra_data_z), .ra_hazard(ra_hazard_z),
    .rb_addr(rb_addr), .rb_data(rb_data_z), .rb_hazard(rb_hazard_z),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy(busy_z)
  );

  reg_file_bypass #(.WIDTH(16), .DEPTH(6), .AW(3), .ZERO_REG(0)) dut_d (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .ra_data(ra_data_d), .ra_hazard(ra_hazard_d),
    .rb_addr(rb_addr), .rb_data(rb_data_d), .rb_hazard(rb_hazard_d),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy(busy_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int id, input int sel, input logic r, input logic w,
                              input logic [2:0] wa, input logic [15:0] wd,
                              input logic [2:0] a, input logic [2:0] b,
                              input logic is, input logic [2:0] ia,
                              input logic [15:0] era, input logic [15:0] erb,
                              input logic eha, input logic ehb, input logic [7:0] eb);
    vec_t v;
    v.id = id; v.sel = sel; v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd;
    v.ra = a; v.rb = b; v.iss = is; v.iaddr = ia;
    v.exp_ra = era; v.exp_rb = erb; v.exp_ha = eha; v.exp_hb = ehb; v.exp_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec %0d: got %h want %h", name, id, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge; optionally queue its expectations.
  task automatic apply(input vec_t v, input bit check);
    @(posedge clk);
    #1;
    rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata;
    ra_addr = v.ra; rb_addr = v.rb; iss_valid = v.iss; iss_addr = v.iaddr;
    if (check) exp_q.push_back(v);
  endtask

  // Outputs are sampled on the falling edge, mid-cycle, against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t v;
      v = exp_q.pop_front();
      case (v.sel)
        0: begin
          chk("ra_data", v.id, ra_data, v.exp_ra);
          chk("rb_data", v.id, rb_data, v.exp_rb);
          chk("ra_hazard", v.id, 16'(ra_hazard), 16'(v.exp_ha));
          chk("rb_hazard", v.id, 16'(rb_hazard), 16'(v.exp_hb));
          chk("busy", v.id, 16'(busy), 16'(v.exp_busy));
        end
        1: begin
          chk("z_ra_data", v.id, ra_data_z, v.exp_ra);
          chk("z_rb_data", v.id, rb_data_z, v.exp_rb);
          chk("z_ra_hazard", v.id, 16'(ra_hazard_z), 16'(v.exp_ha));
          chk("z_rb_hazard", v.id, 16'(rb_hazard_z), 16'(v.exp_hb));
          chk("z_busy", v.id, 16'(busy_z), 16'(v.exp_busy));
        end
        default: begin
          chk("d_ra_data", v.id, ra_data_d, v.exp_ra);
          chk("d_rb_data", v.id, rb_data_d, v.exp_rb);
          chk("d_ra_hazard", v.id, 16'(ra_hazard_d), 16'(v.exp_ha));
          chk("d_rb_hazard", v.id, 16'(rb_hazard_d), 16'(v.exp_hb));
          chk("d_busy", v.id, 16'(busy_d), 16'(v.exp_busy));
        end
      endcase
    end
  end

  initial begin
    vec_t idle;
    //            id sel rst we wa  wdata     ra rb iss ia  exp_ra    exp_rb    ha hb busy
    tbl[0]  = mk( 0, 0, 0, 0, 0, 16'h0000, 0, 7, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00);
    tbl[1]  = mk( 1, 0, 0, 1, 3, 16'hBEEF, 3, 0, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 8'h00);
    tbl[2]  = mk( 2, 0, 1, 1, 3, 16'h1234, 3, 3, 1, 1, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00);
    tbl[3]  = mk( 3, 0, 0, 0, 0, 16'h0000, 3, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00);
    tbl[4]  = mk( 4, 0, 0, 1, 5, 16'hA5A5, 5, 5, 0, 0, 16'hA5A5, 16'hA5A5, 0, 0, 8'h00);
    tbl[5]  = mk( 5, 0, 0, 0, 0, 16'h0000, 5, 5, 0, 0, 16'hA5A5, 16'hA5A5, 0, 0, 8'h00);
    tbl[6]  = mk( 6, 0, 0, 0, 0, 16'h0000, 2, 5, 1, 2, 16'h0000, 16'hA5A5, 0, 0, 8'h00);
    tbl[7]  = mk( 7, 0, 0, 0, 0, 16'h0000, 2, 2, 0, 0, 16'h0000, 16'h0000, 1, 1, 8'h04);
    tbl[8]  = mk( 8, 0, 0, 1, 2, 16'h0042, 2, 6, 0, 0, 16'h0042, 16'h0000, 0, 0, 8'h04);
    tbl[9]  = mk( 9, 0, 0, 0, 0, 16'h0000, 2, 5, 0, 0, 16'h0042, 16'hA5A5, 0, 0, 8'h00);
    tbl[10] = mk(10, 0, 0, 0, 0, 16'h0000, 4, 0, 1, 4, 16'h0000, 16'h0000, 0, 0, 8'h00);
    tbl[11] = mk(11, 0, 0, 1, 4, 16'h4444, 4, 4, 1, 4, 16'h4444, 16'h4444, 0, 0, 8'h10);
    tbl[12] = mk(12, 0, 0, 0, 0, 16'h0000, 4, 4, 0, 0, 16'h4444, 16'h4444, 1, 1, 8'h10);
    tbl[13] = mk(13, 0, 0, 1, 4, 16'h5555, 4, 6, 1, 6, 16'h5555, 16'h0000, 0, 0, 8'h10);
    tbl[14] = mk(14, 0, 0, 0, 0, 16'h0000, 4, 6, 0, 0, 16'h5555, 16'h0000, 0, 1, 8'h40);
    tbl[15] = mk(15, 0, 0, 1, 1, 16'h0101, 6, 1, 1, 6, 16'h0000, 16'h0101, 1, 0, 8'h40);
    tbl[16] = mk(16, 0, 0, 0, 0, 16'h0000, 1, 6, 0, 0, 16'h0101, 16'h0000, 0, 1, 8'h40);
    tbl[17] = mk(17, 0, 1, 0, 0, 16'h0000, 6, 1, 0, 0, 16'h0000, 16'h0101, 0, 0, 8'h40);
    tbl[18] = mk(18, 0, 0, 0, 0, 16'h0000, 1, 6, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00);

    idle = mk(-1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00);
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    ra_addr = '0; rb_addr = '0; iss_valid = 1'b0; iss_addr = '0;

    // Reset all builds, then the default-build table.
    apply(idle, 0);
    apply(idle, 0);
    for (int i = 0; i < 19; i++) apply(tbl[i], 1);

    // Hard-wired zero register: writes and issues to r0 are dropped, r1 behaves normally.
    apply(idle, 0);
    apply(mk(100, 1, 0, 1, 0, 16'hFFFF, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 8'h00), 1);
    apply(mk(101, 1, 0, 1, 1, 16'h0101, 0, 1, 1, 1, 16'h0000, 16'h0101, 0, 0, 8'h00), 1);
    apply(mk(102, 1, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0101, 0, 1, 8'h02), 1);

    // DEPTH=6 build: addresses 6 and 7 are out of range for writes, reads and issues.
    apply(idle, 0);
    apply(mk(200, 2, 0, 1, 5, 16'h2222, 5, 7, 0, 0, 16'h2222, 16'h0000, 0, 0, 8'h00), 1);
    apply(mk(201, 2, 0, 1, 7, 16'h1111, 7, 5, 1, 7, 16'h0000, 16'h2222, 0, 0, 8'h00), 1);
    apply(mk(202, 2, 0, 1, 6, 16'h1111, 6, 7, 1, 6, 16'h0000, 16'h0000, 0, 0, 8'h00), 1);
    apply(mk(203, 2, 0, 0, 0, 16'h0000, 5, 7, 0, 0, 16'h2222, 16'h0000, 0, 0, 8'h00), 1);
    apply(mk(204, 2, 0, 0, 0, 16'h0000, 6, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00), 1);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_bypass.md
Name: reg_file_bypass

Overview:
- Parametrised general-purpose register file with one write port and two read ports.
- Same-cycle write-to-read bypass on both read ports.
- Per-register busy scoreboard: the issue stage marks a destination pending; writeback clears it.
- Sits between decode/issue and the ALU writeback path of the 16-bit processor. Generalises the single bypassed register into an addressable array with hazard reporting.

Parameters:
- WIDTH, 16, data width of each register in bits.
- DEPTH, 8, number of registers; 2..256.
- AW, 3, address width; must satisfy 2^AW >= DEPTH.
- ZERO_REG, 0, if 1 register 0 is hard-wired to zero: writes ignored, never busy.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable (writeback).
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- ra_addr  input  AW  read port A address.
- ra_data  output  WIDTH  read port A data (combinational).
- ra_hazard  output  1  port A source pending, data not yet available.
- rb_addr  input  AW  read port B address.
- rb_data  output  WIDTH  read port B data (combinational).
- rb_hazard  output  1  port B source pending.
- iss_valid  input  1  issue marks destination busy.
- iss_addr  input  AW  destination register being issued.
- busy  output  DEPTH  scoreboard vector, bit i = register i pending.

Behaviour:
- Storage: DEPTH x WIDTH flops, all cleared to 0 on any rising edge with rst=1.
- Reset:
  - busy cleared to all zeros on reset.
  - Reset has priority over we and iss_valid in that cycle.
  - While rst=1, bypass is suppressed and hazards read 0, so ra_data/rb_data show stored contents. Reset asserted mid-operation discards in-flight writes and issues.
- Write: on rising edge with rst=0, we=1, and a valid waddr, reg[waddr] <= wdata. The written value is visible at the stored output on the next cycle.
- Valid address means addr < DEPTH and not (ZERO_REG=1 and addr=0).
  - A write to an invalid address is ignored.
  - A read from addr >= DEPTH returns 0 with hazard 0.
- Bypass (per read port X):
  - X_data = wdata when rst=0, we=1, waddr valid, and waddr==X_addr.
  - Otherwise X_data = reg[X_addr].
  - Latency 0: data written this cycle is readable the same cycle.
  - Both ports may bypass simultaneously, including when reading the same address.
- ZERO_REG=1: reads of address 0 always return 0, never bypass, hazard 0.
- Scoreboard, on rising edge with rst=0:
  - Clear: we=1 and waddr valid -> busy[waddr] <= 0.
  - Set: iss_valid=1 and iss_addr valid -> busy[iss_addr] <= 1.
  - Same address both cleared and set in one cycle -> set wins (new producer issued), busy stays 1.
  - Different addresses -> both actions apply.
  - Write to a non-busy register is legal; busy remains 0.
  - Issue to an already-busy register is legal; busy remains 1 (single pending bit, no count).
- Hazard (combinational): X_hazard = busy[X_addr] and not (we=1 and waddr==X_addr and waddr valid). A same-cycle writeback resolves the hazard through the bypass.
- No internal stall: the consumer stalls on ra_hazard/rb_hazard.
- No X-propagation: every output is defined for all input values after the first reset.

Test Plan:
- Reset clears state: write 0xBEEF to r3, then assert rst for 1 cycle with we=1, waddr=3, wdata=0x1234 -> next cycle ra_addr=3 gives ra_data=0x0000, busy=0x00.
- Same-cycle bypass: we=1, waddr=5, wdata=0xA5A5, ra_addr=rb_addr=5 -> both data outputs 0xA5A5 that cycle. Next cycle with we=0 -> still 0xA5A5 from storage.
- Scoreboard lifecycle:
  - iss_valid=1, iss_addr=2 -> next cycle busy=0x04, ra_addr=2 gives ra_hazard=1.
  - Then we=1, waddr=2, wdata=0x0042 -> same cycle ra_hazard=0, ra_data=0x0042; next cycle busy=0x00.
- Simultaneous set/clear on r4 (busy[4]=1): we=1, waddr=4 and iss_valid=1, iss_addr=4 in the same cycle -> busy[4] stays 1, reg[4] updated.
- ZERO_REG=1 build: we=1, waddr=0, wdata=0xFFFF and iss_valid=1, iss_addr=0 -> ra_addr=0 gives 0x0000, ra_hazard=0, busy[0]=0.
- DEPTH=6, AW=3 build:
  - Write 0x1111 to addr 7 -> no register changes.
  - ra_addr=7 -> 0x0000, hazard 0.
  - iss_addr=7 -> busy unchanged.
